// File: rtl/acc_pkg.sv
// Shared types for the accelerator Xmem arbiter: request payload, request
// type, arbiter index and FSM state encoding.
package acc_pkg;

  localparam int unsigned AccNumReq      = 2;
  localparam int unsigned AccIdFifoDepth = 4;

  // Index of one requester for the default configuration.
  typedef logic [$clog2(AccNumReq)-1:0] acc_idx_t;

  typedef enum logic {
    MEM_READ  = 1'b0,
    MEM_WRITE = 1'b1
  } mem_req_type_e;

  // Everything that travels with a request beat; muxed as one unit.
  typedef struct packed {
    logic [31:0]   laddr;
    logic [31:0]   wdata;
    logic [2:0]    width;
    mem_req_type_e req_type;
    logic          mode;
    logic          spec;
    logic          endoftransaction;
  } acc_req_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/acc_xmem_arbiter_if.sv
// Bundle of the accelerator-side request/response channels and the single
// core-side Xmem channel. "slave" is the arbiter's view, "master" is the
// view of the surrounding accelerators plus core.
interface acc_xmem_arbiter_if #(
  parameter int unsigned NumReq = acc_pkg::AccNumReq
);
  import acc_pkg::*;

  // Accelerator request channel
  logic [NumReq-1:0]             req_q_valid_i;
  logic [NumReq-1:0]             req_q_ready_o;
  logic [NumReq-1:0][31:0]       req_q_laddr_i;
  logic [NumReq-1:0][31:0]       req_q_wdata_i;
  logic [NumReq-1:0][2:0]        req_q_width_i;
  mem_req_type_e [NumReq-1:0]    req_q_req_type_i;
  logic [NumReq-1:0]             req_q_mode_i;
  logic [NumReq-1:0]             req_q_spec_i;
  logic [NumReq-1:0]             req_q_endoftransaction_i;

  // Accelerator response channel
  logic [NumReq-1:0]             req_p_valid_o;
  logic [NumReq-1:0]             req_p_ready_i;
  logic [31:0]                   req_p_rdata_o;
  logic [4:0]                    req_p_range_o;
  logic                          req_p_status_o;

  // Core request channel
  logic                          xmem_q_valid_o;
  logic                          xmem_q_ready_i;
  logic [31:0]                   xmem_q_laddr_o;
  logic [31:0]                   xmem_q_wdata_o;
  logic [2:0]                    xmem_q_width_o;
  mem_req_type_e                 xmem_q_req_type_o;
  logic                          xmem_q_mode_o;
  logic                          xmem_q_spec_o;
  logic                          xmem_q_endoftransaction_o;

  // Core response channel
  logic                          xmem_p_valid_i;
  logic                          xmem_p_ready_o;
  logic [31:0]                   xmem_p_rdata_i;
  logic [4:0]                    xmem_p_range_i;
  logic                          xmem_p_status_i;

  logic                          unexpected_rsp_o;

  modport slave (
    input  req_q_valid_i, req_q_laddr_i, req_q_wdata_i, req_q_width_i,
           req_q_req_type_i, req_q_mode_i, req_q_spec_i, req_q_endoftransaction_i,
           req_p_ready_i, xmem_q_ready_i,
           xmem_p_valid_i, xmem_p_rdata_i, xmem_p_range_i, xmem_p_status_i,
    output req_q_ready_o, req_p_valid_o, req_p_rdata_o, req_p_range_o, req_p_status_o,
           xmem_q_valid_o, xmem_q_laddr_o, xmem_q_wdata_o, xmem_q_width_o,
           xmem_q_req_type_o, xmem_q_mode_o, xmem_q_spec_o, xmem_q_endoftransaction_o,
           xmem_p_ready_o, unexpected_rsp_o
  );

  modport master (
    output req_q_valid_i, req_q_laddr_i, req_q_wdata_i, req_q_width_i,
           req_q_req_type_i, req_q_mode_i, req_q_spec_i, req_q_endoftransaction_i,
           req_p_ready_i, xmem_q_ready_i,
           xmem_p_valid_i, xmem_p_rdata_i, xmem_p_range_i, xmem_p_status_i,
    input  req_q_ready_o, req_p_valid_o, req_p_rdata_o, req_p_range_o, req_p_status_o,
           xmem_q_valid_o, xmem_q_laddr_o, xmem_q_wdata_o, xmem_q_width_o,
           xmem_q_req_type_o, xmem_q_mode_o, xmem_q_spec_o, xmem_q_endoftransaction_o,
           xmem_p_ready_o, unexpected_rsp_o
  );

endinterface

// File: rtl/acc_id_fifo.sv
// Small FIFO holding the requester index of every accepted request so that
// in-order responses can be routed back. Push is ignored when full and pop
// is ignored when empty; there is no full-state bypass.
module acc_id_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [Width-1:0] head_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q;
  logic [PtrW-1:0]  rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full_o    = (count_q == (PtrW+1)'(Depth));
  assign empty_o   = (count_q == '0);
  assign push_ok_s = push_i & ~full_o;
  assign pop_ok_s  = pop_i & ~empty_o;
  assign head_o    = mem_q[rd_ptr_q];

  // Storage, wrapping pointers (Depth is a power of two) and occupancy count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok_s) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_q <= count_q + (PtrW+1)'(1);
        2'b01:   count_q <= count_q - (PtrW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/acc_xmem_arbiter.sv
// Shares the core's single Xmem channel between NumReq accelerators.
// Round-robin grant, grant locked across multi-beat transactions until the
// endoftransaction beat, grant frozen while a presented beat is stalled, and
// in-order response routing through an ID FIFO.
module acc_xmem_arbiter
  import acc_pkg::*;
#(
  parameter int unsigned NumReq      = AccNumReq,
  parameter int unsigned IdFifoDepth = AccIdFifoDepth
) (
  input logic               clk_i,
  input logic               rst_ni,
  acc_xmem_arbiter_if.slave bus
);

  localparam int unsigned IdxW = $clog2(NumReq);
  typedef logic [IdxW-1:0] idx_t;

  arb_state_e state_q, state_d;
  idx_t       rr_ptr_q, rr_ptr_d;
  idx_t       lock_id_q, lock_id_d;
  idx_t       g_q, g_d;
  logic       hold_q, hold_d;

  idx_t       grant_s;
  idx_t       head_s;
  acc_req_t   req_s [NumReq];
  acc_req_t   gnt_req_s;
  logic       fifo_full_s;
  logic       fifo_empty_s;
  logic       q_valid_s;
  logic       q_hs_s;
  logic       p_ready_s;
  logic       pop_s;

  // (base + off) mod NumReq for off < NumReq, valid for any NumReq.
  function automatic idx_t wrap_add(idx_t base, int unsigned off);
    int unsigned sum;
    sum = 32'(base) + off;
    sum = (sum >= NumReq) ? (sum - NumReq) : sum;
    return idx_t'(sum);
  endfunction

  // Gather each requester's payload into one struct for muxing.
  always_comb begin
    for (int i = 0; i < int'(NumReq); i++) begin
      req_s[i].laddr            = bus.req_q_laddr_i[i];
      req_s[i].wdata            = bus.req_q_wdata_i[i];
      req_s[i].width            = bus.req_q_width_i[i];
      req_s[i].req_type         = bus.req_q_req_type_i[i];
      req_s[i].mode             = bus.req_q_mode_i[i];
      req_s[i].spec             = bus.req_q_spec_i[i];
      req_s[i].endoftransaction = bus.req_q_endoftransaction_i[i];
    end
  end

  // Grant selection: lock owner, else frozen grant, else round-robin scan.
  // The scan runs backwards so the first valid requester from rr_ptr wins.
  always_comb begin
    grant_s = rr_ptr_q;
    if (state_q == ST_LOCKED) begin
      grant_s = lock_id_q;
    end else if (hold_q) begin
      grant_s = g_q;
    end else begin
      for (int k = int'(NumReq) - 1; k >= 0; k--) begin
        grant_s = bus.req_q_valid_i[wrap_add(rr_ptr_q, 32'(k))] ?
                  wrap_add(rr_ptr_q, 32'(k)) : grant_s;
      end
    end
  end

  assign gnt_req_s = req_s[grant_s];
  assign q_valid_s = bus.req_q_valid_i[grant_s] & ~fifo_full_s;
  assign q_hs_s    = q_valid_s & bus.xmem_q_ready_i;

  assign bus.xmem_q_valid_o            = q_valid_s;
  assign bus.xmem_q_laddr_o            = gnt_req_s.laddr;
  assign bus.xmem_q_wdata_o            = gnt_req_s.wdata;
  assign bus.xmem_q_width_o            = gnt_req_s.width;
  assign bus.xmem_q_req_type_o         = gnt_req_s.req_type;
  assign bus.xmem_q_mode_o             = gnt_req_s.mode;
  assign bus.xmem_q_spec_o             = gnt_req_s.spec;
  assign bus.xmem_q_endoftransaction_o = gnt_req_s.endoftransaction;

  // Only the granted requester may see ready.
  always_comb begin
    bus.req_q_ready_o          = '0;
    bus.req_q_ready_o[grant_s] = bus.xmem_q_ready_i & ~fifo_full_s;
  end

  // Response routing to the FIFO head; drain mode while nothing is pending.
  always_comb begin
    bus.req_p_valid_o         = '0;
    bus.req_p_valid_o[head_s] = bus.xmem_p_valid_i & ~fifo_empty_s;
    if (fifo_empty_s) begin
      p_ready_s = 1'b1;
    end else begin
      p_ready_s = bus.req_p_ready_i[head_s];
    end
  end

  assign pop_s                = bus.xmem_p_valid_i & p_ready_s & ~fifo_empty_s;
  assign bus.xmem_p_ready_o   = p_ready_s;
  assign bus.unexpected_rsp_o = bus.xmem_p_valid_i & fifo_empty_s;
  assign bus.req_p_rdata_o    = bus.xmem_p_rdata_i;
  assign bus.req_p_range_o    = bus.xmem_p_range_i;
  assign bus.req_p_status_o   = bus.xmem_p_status_i;

  // Next-state: lock/unlock and rr advance on handshake, freeze grant on stall.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    lock_id_d = lock_id_q;
    g_d       = g_q;
    hold_d    = hold_q;
    if (q_hs_s) begin
      hold_d = 1'b0;
      if (gnt_req_s.endoftransaction) begin
        state_d  = ST_IDLE;
        rr_ptr_d = wrap_add(grant_s, 32'd1);
      end else begin
        state_d   = ST_LOCKED;
        lock_id_d = grant_s;
      end
    end else if (q_valid_s) begin
      hold_d = 1'b1;
      g_d    = grant_s;
    end else begin
      hold_d = hold_q;
    end
  end

  // Arbiter state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= '0;
      lock_id_q <= '0;
      g_q       <= '0;
      hold_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      lock_id_q <= lock_id_d;
      g_q       <= g_d;
      hold_q    <= hold_d;
    end
  end

  acc_id_fifo #(
    .Depth (IdFifoDepth),
    .Width (IdxW)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (q_hs_s),
    .data_i  (grant_s),
    .pop_i   (pop_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .head_o  (head_s)
  );

endmodule

// File: tb/tb_acc_xmem_arbiter.sv
// Bench for acc_xmem_arbiter: a vector table, directed multi-cycle
// sequences and a randomized run against a queue-based reference model.
module tb_acc_xmem_arbiter;
  import acc_pkg::*;

  localparam int NREQ  = 2;
  localparam int DEPTH = 4;

  logic clk;
  logic rst_n;
  int   n_cmp  = 0;
  int   n_fail = 0;

  acc_xmem_arbiter_if #(.NumReq(NREQ)) bus ();

  acc_xmem_arbiter #(.NumReq(NREQ), .IdFifoDepth(DEPTH)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  qv;
    logic        qrdy;
    logic [1:0]  eot;
    logic        pv;
    logic [1:0]  prdy;
    logic [1:0]  e_qready;
    logic        e_qvalid;
    logic [31:0] e_laddr;
    logic [1:0]  e_pvalid;
    logic        e_pready;
    logic        e_unexp;
  } vec_t;

  vec_t tbl [8];

  // Reference model state
  int m_rr;
  bit m_locked;
  int m_lock;
  bit m_hold;
  int m_g;
  int m_fifo [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    bus.req_q_valid_i            = 2'b00;
    bus.req_q_endoftransaction_i = 2'b11;
    bus.req_q_mode_i             = 2'b00;
    bus.req_q_spec_i             = 2'b00;
    bus.req_q_req_type_i         = {MEM_READ, MEM_READ};
    bus.req_q_width_i[0]         = 3'd2;
    bus.req_q_width_i[1]         = 3'd2;
    bus.req_q_laddr_i[0]         = 32'hA000_0000;
    bus.req_q_laddr_i[1]         = 32'hB000_0000;
    bus.req_q_wdata_i[0]         = 32'h0;
    bus.req_q_wdata_i[1]         = 32'h0;
    bus.req_p_ready_i            = 2'b11;
    bus.xmem_q_ready_i           = 1'b0;
    bus.xmem_p_valid_i           = 1'b0;
    bus.xmem_p_rdata_i           = 32'h0;
    bus.xmem_p_range_i           = 5'd0;
    bus.xmem_p_status_i          = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #2;
    chk("rst_q_ready", 32'(bus.req_q_ready_o), 32'h0);
    chk("rst_p_valid", 32'(bus.req_p_valid_o), 32'h0);
    chk("rst_q_valid", 32'(bus.xmem_q_valid_o), 32'h0);
    chk("rst_unexp", 32'(bus.unexpected_rsp_o), 32'h0);
    chk("rst_p_ready", 32'(bus.xmem_p_ready_o), 32'h1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    m_rr = 0; m_locked = 0; m_lock = 0; m_hold = 0; m_g = 0;
    m_fifo.delete();
  endtask

  // Advance one cycle, drive the control inputs, let the logic settle.
  task automatic cyc(input logic [1:0] qv, input logic qrdy, input logic [1:0] eot,
                     input logic pv, input logic [1:0] prdy);
    @(posedge clk);
    #1;
    bus.req_q_valid_i            = qv;
    bus.xmem_q_ready_i           = qrdy;
    bus.req_q_endoftransaction_i = eot;
    bus.xmem_p_valid_i           = pv;
    bus.req_p_ready_i            = prdy;
    #1;
  endtask

  task automatic rand_phase(input int ncyc);
    logic [1:0]  qv, eot, prdy;
    logic        qrdy, pv;
    logic [31:0] la [NREQ];
    logic [31:0] wd [NREQ];
    logic [31:0] rd;
    int gnt, head;
    bit defd, full, empty, e_qv, e_prdy;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk);
      #1;
      qv   = 2'($urandom_range(0, 3));
      qrdy = ($urandom_range(0, 3) != 0);
      pv   = 1'($urandom_range(0, 1));
      rd   = $urandom;
      for (int i = 0; i < NREQ; i++) begin
        eot[i]  = ($urandom_range(0, 4) != 0);
        prdy[i] = ($urandom_range(0, 3) != 0);
        la[i]   = $urandom;
        wd[i]   = $urandom;
        bus.req_q_laddr_i[i] = la[i];
        bus.req_q_wdata_i[i] = wd[i];
      end
      bus.req_q_valid_i            = qv;
      bus.xmem_q_ready_i           = qrdy;
      bus.req_q_endoftransaction_i = eot;
      bus.xmem_p_valid_i           = pv;
      bus.req_p_ready_i            = prdy;
      bus.xmem_p_rdata_i           = rd;
      #1;
      full  = (m_fifo.size() == DEPTH);
      empty = (m_fifo.size() == 0);
      defd  = 1'b1;
      if (m_locked) gnt = m_lock;
      else if (m_hold) gnt = m_g;
      else begin
        defd = 1'b0;
        gnt  = m_rr;
        for (int k = 0; k < NREQ; k++) begin
          if (!defd && qv[(m_rr + k) % NREQ]) begin
            gnt  = (m_rr + k) % NREQ;
            defd = 1'b1;
          end
        end
      end
      e_qv = qv[gnt] && !full;
      chk("rnd_q_valid", 32'(bus.xmem_q_valid_o), 32'(e_qv));
      if (defd) chk("rnd_q_ready", 32'(bus.req_q_ready_o), (qrdy && !full) ? (32'd1 << gnt) : 32'd0);
      if (e_qv) begin
        chk("rnd_laddr", bus.xmem_q_laddr_o, la[gnt]);
        chk("rnd_wdata", bus.xmem_q_wdata_o, wd[gnt]);
        chk("rnd_eot", 32'(bus.xmem_q_endoftransaction_o), 32'(eot[gnt]));
      end
      head   = empty ? 0 : m_fifo[0];
      e_prdy = empty ? 1'b1 : prdy[head];
      chk("rnd_p_valid", 32'(bus.req_p_valid_o), (pv && !empty) ? (32'd1 << head) : 32'd0);
      chk("rnd_p_ready", 32'(bus.xmem_p_ready_o), 32'(e_prdy));
      chk("rnd_unexp", 32'(bus.unexpected_rsp_o), 32'(pv && empty));
      chk("rnd_rdata", bus.req_p_rdata_o, rd);
      // Model update for the coming clock edge
      if (pv && e_prdy && !empty) void'(m_fifo.pop_front());
      if (e_qv && qrdy) begin
        m_fifo.push_back(gnt);
        m_hold = 1'b0;
        if (eot[gnt]) begin
          m_locked = 1'b0;
          m_rr     = (gnt + 1) % NREQ;
        end else begin
          m_locked = 1'b1;
          m_lock   = gnt;
        end
      end else if (e_qv) begin
        m_hold = 1'b1;
        m_g    = gnt;
      end
    end
  endtask

  initial begin
    //            qv    rdy   eot   pv    prdy  e_rdy e_qv  e_laddr        e_pv  e_prd e_unx
    tbl[0] = '{2'b11, 1'b1, 2'b11, 1'b0, 2'b11, 2'b01, 1'b1, 32'hA000_0000, 2'b00, 1'b1, 1'b0};
    tbl[1] = '{2'b11, 1'b1, 2'b11, 1'b0, 2'b11, 2'b10, 1'b1, 32'hB000_0000, 2'b00, 1'b1, 1'b0};
    tbl[2] = '{2'b11, 1'b1, 2'b11, 1'b1, 2'b11, 2'b01, 1'b1, 32'hA000_0000, 2'b01, 1'b1, 1'b0};
    tbl[3] = '{2'b11, 1'b1, 2'b11, 1'b1, 2'b11, 2'b10, 1'b1, 32'hB000_0000, 2'b10, 1'b1, 1'b0};
    tbl[4] = '{2'b00, 1'b0, 2'b11, 1'b1, 2'b11, 2'b00, 1'b0, 32'h0,         2'b01, 1'b1, 1'b0};
    tbl[5] = '{2'b00, 1'b0, 2'b11, 1'b1, 2'b11, 2'b00, 1'b0, 32'h0,         2'b10, 1'b1, 1'b0};
    tbl[6] = '{2'b00, 1'b0, 2'b11, 1'b1, 2'b11, 2'b00, 1'b0, 32'h0,         2'b00, 1'b1, 1'b1};
    tbl[7] = '{2'b00, 1'b0, 2'b11, 1'b0, 2'b11, 2'b00, 1'b0, 32'h0,         2'b00, 1'b1, 1'b0};

    // Alternating single-beat grants with in-order responses
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cyc(tbl[i].qv, tbl[i].qrdy, tbl[i].eot, tbl[i].pv, tbl[i].prdy);
      chk($sformatf("tbl%0d_q_ready", i), 32'(bus.req_q_ready_o), 32'(tbl[i].e_qready));
      chk($sformatf("tbl%0d_q_valid", i), 32'(bus.xmem_q_valid_o), 32'(tbl[i].e_qvalid));
      if (tbl[i].e_qvalid) chk($sformatf("tbl%0d_laddr", i), bus.xmem_q_laddr_o, tbl[i].e_laddr);
      chk($sformatf("tbl%0d_p_valid", i), 32'(bus.req_p_valid_o), 32'(tbl[i].e_pvalid));
      chk($sformatf("tbl%0d_p_ready", i), 32'(bus.xmem_p_ready_o), 32'(tbl[i].e_pready));
      chk($sformatf("tbl%0d_unexp", i), 32'(bus.unexpected_rsp_o), 32'(tbl[i].e_unexp));
    end

    // Three-beat lock by requester 0 while requester 1 waits
    do_reset();
    cyc(2'b11, 1'b1, 2'b10, 1'b0, 2'b11);
    chk("lock_b1_ready", 32'(bus.req_q_ready_o), 32'h1);
    chk("lock_b1_laddr", bus.xmem_q_laddr_o, 32'hA000_0000);
    cyc(2'b10, 1'b1, 2'b10, 1'b0, 2'b11);
    chk("lock_idle_ready", 32'(bus.req_q_ready_o), 32'h1);
    chk("lock_idle_valid", 32'(bus.xmem_q_valid_o), 32'h0);
    cyc(2'b11, 1'b1, 2'b10, 1'b0, 2'b11);
    chk("lock_b2_ready", 32'(bus.req_q_ready_o), 32'h1);
    cyc(2'b11, 1'b1, 2'b11, 1'b0, 2'b11);
    chk("lock_b3_ready", 32'(bus.req_q_ready_o), 32'h1);
    cyc(2'b11, 1'b1, 2'b11, 1'b0, 2'b11);
    chk("lock_next_ready", 32'(bus.req_q_ready_o), 32'h2);
    chk("lock_next_laddr", bus.xmem_q_laddr_o, 32'hB000_0000);

    // Stalled beat keeps grant and payload while a competitor appears
    do_reset();
    cyc(2'b01, 1'b1, 2'b11, 1'b0, 2'b11);
    chk("hold_pre_ready", 32'(bus.req_q_ready_o), 32'h1);
    bus.req_q_laddr_i[0] = 32'h0000_1234;
    bus.req_q_wdata_i[0] = 32'hDEAD_BEEF;
    for (int c = 0; c < 5; c++) begin
      cyc((c >= 2) ? 2'b11 : 2'b01, 1'b0, 2'b11, 1'b0, 2'b11);
      chk($sformatf("hold%0d_valid", c), 32'(bus.xmem_q_valid_o), 32'h1);
      chk($sformatf("hold%0d_laddr", c), bus.xmem_q_laddr_o, 32'h0000_1234);
      chk($sformatf("hold%0d_wdata", c), bus.xmem_q_wdata_o, 32'hDEAD_BEEF);
    end
    cyc(2'b11, 1'b1, 2'b11, 1'b0, 2'b11);
    chk("hold_hs_ready", 32'(bus.req_q_ready_o), 32'h1);
    chk("hold_hs_laddr", bus.xmem_q_laddr_o, 32'h0000_1234);
    cyc(2'b10, 1'b1, 2'b11, 1'b0, 2'b11);
    chk("hold_after_ready", 32'(bus.req_q_ready_o), 32'h2);

    // ID FIFO full back-pressure, released one cycle after a pop
    do_reset();
    for (int c = 0; c < DEPTH; c++) begin
      cyc(2'b01, 1'b1, 2'b11, 1'b0, 2'b11);
      chk($sformatf("fill%0d_ready", c), 32'(bus.req_q_ready_o), 32'h1);
    end
    cyc(2'b01, 1'b1, 2'b11, 1'b1, 2'b11);
    chk("full_q_valid", 32'(bus.xmem_q_valid_o), 32'h0);
    chk("full_q_ready", 32'(bus.req_q_ready_o), 32'h0);
    chk("full_p_valid", 32'(bus.req_p_valid_o), 32'h1);
    cyc(2'b01, 1'b1, 2'b11, 1'b0, 2'b11);
    chk("unfull_q_valid", 32'(bus.xmem_q_valid_o), 32'h1);
    chk("unfull_q_ready", 32'(bus.req_q_ready_o), 32'h1);

    // Response stall for requester 1, then an unexpected response
    do_reset();
    cyc(2'b10, 1'b1, 2'b11, 1'b0, 2'b11);
    chk("rsp_req_ready", 32'(bus.req_q_ready_o), 32'h2);
    bus.xmem_p_rdata_i = 32'h5A5A_0001;
    for (int c = 0; c < 3; c++) begin
      cyc(2'b00, 1'b0, 2'b11, 1'b1, 2'b01);
      chk($sformatf("stall%0d_p_ready", c), 32'(bus.xmem_p_ready_o), 32'h0);
      chk($sformatf("stall%0d_p_valid", c), 32'(bus.req_p_valid_o), 32'h2);
    end
    cyc(2'b00, 1'b0, 2'b11, 1'b1, 2'b11);
    chk("stall_rel_p_ready", 32'(bus.xmem_p_ready_o), 32'h1);
    chk("stall_rel_p_valid", 32'(bus.req_p_valid_o), 32'h2);
    chk("stall_rel_rdata", bus.req_p_rdata_o, 32'h5A5A_0001);
    cyc(2'b00, 1'b0, 2'b11, 1'b1, 2'b11);
    chk("unexp_pulse", 32'(bus.unexpected_rsp_o), 32'h1);
    chk("unexp_p_valid", 32'(bus.req_p_valid_o), 32'h0);
    chk("unexp_p_ready", 32'(bus.xmem_p_ready_o), 32'h1);
    cyc(2'b00, 1'b0, 2'b11, 1'b0, 2'b11);
    chk("unexp_end", 32'(bus.unexpected_rsp_o), 32'h0);

    // Randomized traffic against the reference model
    do_reset();
    rand_phase(1500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
